// File: rtl/mem_xfer_ctrl_pkg.sv
// Shared constants and FSM state type for the memory-to-memory transfer sequencer.
package mem_xfer_ctrl_pkg;

  localparam int unsigned AW_DEF = 4;
  localparam int unsigned DW_DEF = 8;
  localparam int unsigned LW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_xfer_ctrl_if.sv
// Memory-side bus: read port of memory A and write port of memory B.
interface mem_xfer_ctrl_if
  import mem_xfer_ctrl_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) ();

  logic          a_rd_en;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_rdata;
  logic          b_wr_en;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;

  modport master (
    output a_rd_en, a_addr, b_wr_en, b_addr, b_wdata,
    input  a_rdata
  );

  modport slave (
    input  a_rd_en, a_addr, b_wr_en, b_addr, b_wdata,
    output a_rdata
  );

endinterface

// File: rtl/mem_xfer_ctrl_xfer_addr_gen.sv
// Source/destination pointers and word counter for one transfer, with last-word flag.
module xfer_addr_gen
  import mem_xfer_ctrl_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned LW = LW_DEF
) (
  input  logic          clock,
  input  logic          Reset,
  input  logic          load,
  input  logic          clr,
  input  logic          inc,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [LW-1:0] len,
  output logic [AW-1:0] src_ptr,
  output logic [AW-1:0] dst_ptr,
  output logic [LW-1:0] count,
  output logic          last
);

  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    cnt_d = cnt_q;
    if (load) begin
      src_d = src_base;
      dst_d = dst_base;
      len_d = len;
    end
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      // Pointers wrap naturally at AW bits.
      src_d = src_q + AW'(1);
      dst_d = dst_q + AW'(1);
      cnt_d = cnt_q + LW'(1);
    end
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

  assign src_ptr = src_q;
  assign dst_ptr = dst_q;
  assign count   = cnt_q;
  assign last    = (cnt_q + LW'(1)) == len_q;

endmodule

// File: rtl/mem_xfer_ctrl.sv
// Sequencer copying LEN words from memory A to memory B, one read then one write per word.
module mem_xfer_ctrl
  import mem_xfer_ctrl_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned LW = LW_DEF
) (
  input  logic                   clock,
  input  logic                   Reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [AW-1:0]          src_base,
  input  logic [AW-1:0]          dst_base,
  input  logic [LW-1:0]          len,
  mem_xfer_ctrl_if.master        mem,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [LW-1:0]          xfer_count
);

  state_t        state_q, state_d;
  logic          aborted_q, aborted_d;
  logic [AW-1:0] a_addr_q, a_addr_d;
  logic [AW-1:0] b_addr_q, b_addr_d;

  logic          load, clr, inc, last;
  logic          rd, wr;
  logic [AW-1:0] src_ptr, dst_ptr;
  logic [DW-1:0] wdata;

  xfer_addr_gen #(
    .AW (AW),
    .LW (LW)
  ) u_addr_gen (
    .clock    (clock),
    .Reset    (Reset),
    .load     (load),
    .clr      (clr),
    .inc      (inc),
    .src_base (src_base),
    .dst_base (dst_base),
    .len      (len),
    .src_ptr  (src_ptr),
    .dst_ptr  (dst_ptr),
    .count    (xfer_count),
    .last     (last)
  );

  always_comb begin
    state_d   = state_q;
    aborted_d = 1'b0;
    load      = 1'b0;
    clr       = 1'b0;
    inc       = 1'b0;
    rd        = 1'b0;
    wr        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clr = 1'b1;
          if (len != '0) begin
            load    = 1'b1;
            state_d = RD;
          end else begin
            state_d = FIN;
          end
        end
      end
      RD: begin
        rd = 1'b1;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = WR;
        end
      end
      WR: begin
        // The write in an aborting WR cycle still lands and is counted.
        wr  = 1'b1;
        inc = 1'b1;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (last) begin
          state_d = FIN;
        end else begin
          state_d = RD;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    a_addr_d = rd ? src_ptr : a_addr_q;
    b_addr_d = wr ? dst_ptr : b_addr_q;
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      aborted_q <= 1'b0;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
    end else begin
      state_q   <= state_d;
      aborted_q <= aborted_d;
      a_addr_q  <= a_addr_d;
      b_addr_q  <= b_addr_d;
    end
  end

  assign wdata = wr ? mem.a_rdata : '0;

  assign mem.a_rd_en = rd;
  assign mem.a_addr  = a_addr_d;
  assign mem.b_wr_en = wr;
  assign mem.b_addr  = b_addr_d;
  assign mem.b_wdata = wdata;

  assign busy    = (state_q == RD) || (state_q == WR);
  assign done    = (state_q == FIN);
  assign aborted = aborted_q;

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Scoreboard bench for mem_xfer_ctrl: expected reads, writes and completion events are queued by the driver and checked by a monitor.
module tb_mem_xfer_ctrl;
  import mem_xfer_ctrl_pkg::*;

  localparam int AW = int'(AW_DEF);
  localparam int DW = int'(DW_DEF);
  localparam int LW = int'(LW_DEF);
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          Reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, aborted;
  logic [LW-1:0] xfer_count;

  mem_xfer_ctrl_if #(.AW(AW), .DW(DW)) mem_if ();

  mem_xfer_ctrl #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clock      (clock),
    .Reset      (Reset),
    .start      (start),
    .abort      (abort),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .len        (len),
    .mem        (mem_if),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .xfer_count (xfer_count)
  );

  logic [DW-1:0] mem_a [DEPTH];
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {int addr; int data;} wr_t;
  typedef struct {bit is_done; int cnt; int cyc;} ev_t;
  int  rd_q[$];
  wr_t wr_q[$];
  ev_t ev_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (mem_if.a_rd_en) mem_if.a_rdata <= mem_a[mem_if.a_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (!Reset) begin
      chk("strobe_excl", 32'(mem_if.a_rd_en & mem_if.b_wr_en), 0);
      if (mem_if.a_rd_en) begin
        chk("read_expected", 32'(rd_q.size() > 0), 1);
        if (rd_q.size() > 0) chk("rd_addr", 32'(mem_if.a_addr), rd_q.pop_front());
      end
      if (mem_if.b_wr_en) begin
        chk("write_expected", 32'(wr_q.size() > 0), 1);
        if (wr_q.size() > 0) begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_addr", 32'(mem_if.b_addr), w.addr);
          chk("wr_data", 32'(mem_if.b_wdata), w.data);
        end
      end
      if (done || aborted) begin
        chk("event_expected", 32'(ev_q.size() > 0), 1);
        chk("done_and_aborted", 32'(done & aborted), 0);
        chk("busy_at_event", 32'(busy), 0);
        if (ev_q.size() > 0) begin
          ev_t e;
          e = ev_q.pop_front();
          chk("event_kind_done", 32'(done), 32'(e.is_done));
          chk("event_count", 32'(xfer_count), e.cnt);
          chk("event_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_a_rd_en"}, 32'(mem_if.a_rd_en), 0);
    chk({tag, "_b_wr_en"}, 32'(mem_if.b_wr_en), 0);
    chk({tag, "_a_addr"}, 32'(mem_if.a_addr), 0);
    chk({tag, "_b_addr"}, 32'(mem_if.b_addr), 0);
    chk({tag, "_b_wdata"}, 32'(mem_if.b_wdata), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_aborted"}, 32'(aborted), 0);
    chk({tag, "_count"}, 32'(xfer_count), 0);
  endtask

  // k>0 aborts during the k-th write cycle; words written = k, else n.
  task automatic run_xfer(input int src, input int dst, input int n, input int k,
                          input bit ab_start, input bit busy_start);
    int e;
    int s;
    int total;
    e = (k > 0) ? k : n;
    @(negedge clock);
    s = cyc + 1;
    for (int i = 0; i < e; i++) begin
      rd_q.push_back((src + i) % DEPTH);
      wr_q.push_back('{addr: (dst + i) % DEPTH, data: int'(mem_a[(src + i) % DEPTH])});
    end
    ev_q.push_back('{is_done: (k == 0), cnt: e, cyc: s + 2 * e});
    src_base = src[AW-1:0];
    dst_base = dst[AW-1:0];
    len      = n[LW-1:0];
    start    = 1'b1;
    abort    = ab_start;
    total    = 2 * e + 3;
    for (int c = 1; c <= total; c++) begin
      @(negedge clock);
      if (c == 1) begin
        start = 1'b0;
        abort = 1'b0;
        chk("busy_after_start", 32'(busy), 32'(n != 0));
      end
      if (busy_start && c == 3) begin
        start    = 1'b1;
        len      = LW'(2);
        src_base = src_base + AW'(5);
      end
      if (busy_start && c == 4) start = 1'b0;
      if (k > 0 && c == 2 * k) abort = 1'b1;
      if (k > 0 && c == 2 * k + 1) abort = 1'b0;
    end
    chk("busy_idle", 32'(busy), 0);
    chk("count_hold", 32'(xfer_count), e);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_a[i] = DW'($urandom);
    #2;
    check_zero("reset");
    @(negedge clock);
    Reset = 1'b0;
    @(negedge clock);

    mem_a[2] = 8'h01; mem_a[3] = 8'h01; mem_a[4] = 8'h00; mem_a[5] = 8'h01;
    run_xfer(2, 8, 4, 0, 1'b0, 1'b0);
    run_xfer(7, 3, 0, 0, 1'b0, 1'b0);
    mem_a[14] = 8'h02; mem_a[15] = 8'h03; mem_a[0] = 8'hFF;
    run_xfer(14, 15, 3, 0, 1'b0, 1'b0);
    run_xfer(1, 4, 6, 3, 1'b0, 1'b0);
    run_xfer(9, 12, 6, 0, 1'b0, 1'b1);
    run_xfer(5, 5, 2, 0, 1'b1, 1'b0);
    run_xfer(10, 0, 20, 0, 1'b0, 1'b0);
    run_xfer(3, 6, 5, 1, 1'b0, 1'b0);
    run_xfer(3, 6, 5, 5, 1'b0, 1'b0);

    // Abort while idle must produce nothing.
    @(negedge clock); abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    repeat (2) @(negedge clock);

    for (int t = 0; t < 10; t++) begin
      int n;
      int k;
      n = int'($urandom_range(0, 20));
      k = (n > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, n)) : 0;
      run_xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
               n, k, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Asynchronous reset while in RD.
    @(negedge clock);
    rd_q.push_back(3);
    src_base = AW'(3); dst_base = AW'(4); len = LW'(5); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    #2 Reset = 1'b1;
    #1 check_zero("midreset");
    rd_q.delete(); wr_q.delete(); ev_q.delete();
    @(negedge clock);
    Reset = 1'b0;
    mem_a[0] = 8'hFD;
    run_xfer(0, 0, 1, 0, 1'b0, 1'b0);

    repeat (3) @(negedge clock);
    chk("pending_expectations", rd_q.size() + wr_q.size() + ev_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
